// File: rtl/cnm_soc_top.sv
// cnm_soc_top: single-cycle RV32I core (u_CoNM) with a private byte-addressed
// data RAM. Instructions arrive on inst every cycle; the core publishes its PC.

// Register file: 32 x 32-bit GPRs, two combinational read ports, one write port.
module cnm_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2
);
  logic [31:0] regs [0:31];

  // GPR storage: cleared on reset; x0 is never written so it stays zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0000_0000;
    end else if (i_we && (i_waddr != 5'd0)) begin
      regs[i_waddr] <= i_wdata;
    end
  end

  // Read ports see pre-edge contents; x0 is hardwired to zero
  always_comb begin
    o_rdata1 = (i_raddr1 == 5'd0) ? 32'h0000_0000 : regs[i_raddr1];
    o_rdata2 = (i_raddr2 == 5'd0) ? 32'h0000_0000 : regs[i_raddr2];
  end
endmodule

// Core: decode/execute of the word on i_inst against the current PC.
module cnm_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic [31:0] i_dmem_rdata
);
  logic [31:0] r_pc;
  logic [31:0] w_rs1, w_rs2, w_next_pc, w_rd_data;
  logic        w_rd_we;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;

  assign w_opcode = i_inst[6:0];
  assign w_f3     = i_inst[14:12];
  assign w_imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};
  assign w_imm_s  = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign w_imm_b  = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign w_imm_u  = {i_inst[31:12], 12'h000};
  assign w_imm_j  = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
  assign o_pc     = r_pc;

  // Integer ALU shared by OP and OP-IMM; shifts use the low 5 bits of b
  function automatic logic [31:0] alu_op(input logic [2:0] f3, input logic alt,
                                         input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (f3)
      3'b000:  alu_op = alt ? (a - b) : (a + b);
      3'b001:  alu_op = a << sh;
      3'b010:  alu_op = {31'd0, ($signed(a) < $signed(b))};
      3'b011:  alu_op = {31'd0, (a < b)};
      3'b100:  alu_op = a ^ b;
      3'b101:  alu_op = alt ? 32'($signed(a) >>> sh) : (a >> sh);
      3'b110:  alu_op = a | b;
      3'b111:  alu_op = a & b;
      default: alu_op = a + b;
    endcase
  endfunction

  // Branch condition evaluation; reserved funct3 values never branch
  function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  br_taken = (a == b);
      3'b001:  br_taken = (a != b);
      3'b100:  br_taken = ($signed(a) <  $signed(b));
      3'b101:  br_taken = ($signed(a) >= $signed(b));
      3'b110:  br_taken = (a <  b);
      3'b111:  br_taken = (a >= b);
      default: br_taken = 1'b0;
    endcase
  endfunction

  cnm_regfile u_csregfile (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_rd_we),
    .i_waddr  (i_inst[11:7]),
    .i_wdata  (w_rd_data),
    .i_raddr1 (i_inst[19:15]),
    .i_raddr2 (i_inst[24:20]),
    .o_rdata1 (w_rs1),
    .o_rdata2 (w_rs2)
  );

  // Decode/execute: next PC, GPR writeback and store strobes for this word
  always_comb begin
    w_next_pc    = r_pc + 32'd4;
    w_rd_we      = 1'b0;
    w_rd_data    = 32'h0000_0000;
    o_dmem_addr  = 32'h0000_0000;
    o_dmem_wdata = 32'h0000_0000;
    o_dmem_be    = 4'b0000;
    case (w_opcode)
      7'b0110111: begin
        w_rd_we   = 1'b1;
        w_rd_data = w_imm_u;
      end
      7'b0010111: begin
        w_rd_we   = 1'b1;
        w_rd_data = r_pc + w_imm_u;
      end
      7'b1101111: begin
        w_rd_we   = 1'b1;
        w_rd_data = r_pc + 32'd4;
        w_next_pc = r_pc + w_imm_j;
      end
      7'b1100111: begin
        w_rd_we   = 1'b1;
        w_rd_data = r_pc + 32'd4;
        w_next_pc = (w_rs1 + w_imm_i) & 32'hFFFF_FFFE;
      end
      7'b1100011: begin
        if (br_taken(w_f3, w_rs1, w_rs2)) begin
          w_next_pc = r_pc + w_imm_b;
        end else begin
          w_next_pc = r_pc + 32'd4;
        end
      end
      7'b0000011: begin
        o_dmem_addr = w_rs1 + w_imm_i;
        case (w_f3)
          3'b000: begin w_rd_we = 1'b1; w_rd_data = {{24{i_dmem_rdata[7]}}, i_dmem_rdata[7:0]}; end
          3'b001: begin w_rd_we = 1'b1; w_rd_data = {{16{i_dmem_rdata[15]}}, i_dmem_rdata[15:0]}; end
          3'b010: begin w_rd_we = 1'b1; w_rd_data = i_dmem_rdata; end
          3'b100: begin w_rd_we = 1'b1; w_rd_data = {24'h000000, i_dmem_rdata[7:0]}; end
          3'b101: begin w_rd_we = 1'b1; w_rd_data = {16'h0000, i_dmem_rdata[15:0]}; end
          default: begin w_rd_we = 1'b0; w_rd_data = 32'h0000_0000; end
        endcase
      end
      7'b0100011: begin
        o_dmem_addr  = w_rs1 + w_imm_s;
        o_dmem_wdata = w_rs2;
        case (w_f3)
          3'b000:  o_dmem_be = 4'b0001;
          3'b001:  o_dmem_be = 4'b0011;
          3'b010:  o_dmem_be = 4'b1111;
          default: o_dmem_be = 4'b0000;
        endcase
      end
      7'b0010011: begin
        w_rd_we   = 1'b1;
        w_rd_data = alu_op(w_f3, (w_f3 == 3'b101) && i_inst[30], w_rs1, w_imm_i);
      end
      7'b0110011: begin
        w_rd_we   = 1'b1;
        w_rd_data = alu_op(w_f3, i_inst[30], w_rs1, w_rs2);
      end
      default: begin
        w_rd_we = 1'b0;
      end
    endcase
  end

  // Program counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end
endmodule

// SoC top: core plus little-endian data RAM with wrap-around byte addressing.
module cnm_soc_top #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DMEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  output logic [31:0] inst_addr_o
);
  localparam int AW = $clog2(DMEM_BYTES);

  logic [7:0]    r_mem [0:DMEM_BYTES-1];
  logic [31:0]   w_dmem_addr, w_dmem_wdata, w_dmem_rdata;
  logic [3:0]    w_dmem_be;
  logic [AW-1:0] w_idx [0:3];
  logic          w_unused_addr;

  assign w_unused_addr = ^w_dmem_addr[31:AW];

  cnm_core #(.RESET_PC(RESET_PC)) u_CoNM (
    .clk          (clk),
    .rst          (rst),
    .i_inst       (inst),
    .o_pc         (inst_addr_o),
    .o_dmem_addr  (w_dmem_addr),
    .o_dmem_wdata (w_dmem_wdata),
    .o_dmem_be    (w_dmem_be),
    .i_dmem_rdata (w_dmem_rdata)
  );

  // Byte k of an access lives at (addr+k) modulo the RAM size
  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign w_idx[k] = w_dmem_addr[AW-1:0] + AW'(k);
    assign w_dmem_rdata[8*k +: 8] = r_mem[w_idx[k]];
  end

  // Data RAM: cleared on reset, byte-enabled writes at the clock edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DMEM_BYTES; i++) r_mem[i] <= 8'h00;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_dmem_be[k]) r_mem[w_idx[k]] <= w_dmem_wdata[8*k +: 8];
      end
    end
  end
endmodule

// File: tb/tb_cnm_soc_top.sv
// Randomized bench for cnm_soc_top against an instruction-level RV32I model.
module tb_cnm_soc_top;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic [31:0] inst_addr_o;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  logic [31:0] m_reg [0:31];
  logic [7:0]  m_mem [0:255];
  logic [31:0] m_pc;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  cnm_soc_top dut (.clk(clk), .rst(rst), .inst(inst), .inst_addr_o(inst_addr_o));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h0;
  endtask

  // Architectural effect of one instruction, straight from the ISA rules
  task automatic model_exec(input logic [31:0] w);
    logic [31:0] a, b, ii, is, ib, iu, ij, val, nxt, addr, word;
    logic [4:0] rd, sh;
    logic [2:0] f3;
    logic [7:0] bx [0:3];
    logic wr;
    a = m_reg[w[19:15]]; b = m_reg[w[24:20]];
    rd = w[11:7]; f3 = w[14:12];
    ii = {{20{w[31]}}, w[31:20]};
    is = {{20{w[31]}}, w[31:25], w[11:7]};
    ib = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    iu = {w[31:12], 12'h0};
    ij = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    nxt = m_pc + 32'd4; wr = 1'b0; val = 32'h0;
    if (w[6:0] == 7'h13) b = ii;
    sh = b[4:0];
    case (w[6:0])
      7'h37: begin wr = 1'b1; val = iu; end
      7'h17: begin wr = 1'b1; val = m_pc + iu; end
      7'h6f: begin wr = 1'b1; val = m_pc + 32'd4; nxt = m_pc + ij; end
      7'h67: begin wr = 1'b1; val = m_pc + 32'd4; nxt = (a + ii) & ~32'h1; end
      7'h63: begin
        if ((f3 == 3'd0 && a == b) || (f3 == 3'd1 && a != b) ||
            (f3 == 3'd4 && $signed(a) < $signed(b)) || (f3 == 3'd5 && $signed(a) >= $signed(b)) ||
            (f3 == 3'd6 && a < b) || (f3 == 3'd7 && a >= b))
          nxt = m_pc + ib;
      end
      7'h03: begin
        addr = a + ii;
        for (int k = 0; k < 4; k++) bx[k] = m_mem[8'(addr[7:0] + 8'(k))];
        word = {bx[3], bx[2], bx[1], bx[0]};
        wr = 1'b1;
        if (f3 == 3'd0) val = {{24{word[7]}}, word[7:0]};
        else if (f3 == 3'd1) val = {{16{word[15]}}, word[15:0]};
        else if (f3 == 3'd2) val = word;
        else if (f3 == 3'd4) val = {24'h0, word[7:0]};
        else if (f3 == 3'd5) val = {16'h0, word[15:0]};
        else wr = 1'b0;
      end
      7'h23: begin
        addr = a + is;
        for (int k = 0; k < 4; k++)
          if (k < (f3 == 3'd0 ? 1 : f3 == 3'd1 ? 2 : f3 == 3'd2 ? 4 : 0))
            m_mem[8'(addr[7:0] + 8'(k))] = b[8*k +: 8];
      end
      7'h13, 7'h33: begin
        wr = 1'b1;
        case (f3)
          3'd0: val = (w[6:0] == 7'h33 && w[30]) ? a - b : a + b;
          3'd1: val = a << sh;
          3'd2: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: val = (a < b) ? 32'd1 : 32'd0;
          3'd4: val = a ^ b;
          3'd5: val = w[30] ? 32'($signed(a) >>> sh) : a >> sh;
          3'd6: val = a | b;
          default: val = a & b;
        endcase
      end
      default: wr = 1'b0;
    endcase
    if (wr && rd != 5'd0) m_reg[rd] = val;
    m_pc = nxt;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_pc"}, inst_addr_o, m_pc);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s_x%0d", tag, i), dut.u_CoNM.u_csregfile.regs[i], m_reg[i]);
    for (int i = 0; i < 256; i++)
      check($sformatf("%s_mem%0d", tag, i), {24'h0, dut.r_mem[i]}, {24'h0, m_mem[i]});
  endtask

  // Compare process: every edge with checking enabled, DUT vs model
  always @(posedge clk) begin
    if (chk_en) begin
      #1;
      compare_all("cyc");
    end
  end

  task automatic step(input logic [31:0] w);
    inst = w;
    @(posedge clk);
    model_exec(w);
    #2;
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] r;
    logic [2:0] f3;
    logic [11:0] imm;
    r = $urandom;
    imm = r[11:0];
    f3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 13))
      0: return {r[31:12], pick(), 7'h37};
      1: return {r[31:12], pick(), 7'h17};
      2, 3: begin
        if (f3 == 3'd1) imm = {7'h00, r[4:0]};
        else if (f3 == 3'd5) imm = {1'b0, r[5], 5'h00, r[4:0]};
        return enc_i(imm, pick(), f3, pick(), 7'h13);
      end
      4, 5: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && r[20]) ? 7'h20 : 7'h00, pick(), pick(), f3, pick());
      6, 7: begin
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) f3 = 3'd2;
        return enc_i(imm, pick(), f3, pick(), 7'h03);
      end
      8, 9: return enc_s(imm, pick(), pick(), 3'($urandom_range(0, 2)));
      10: begin
        if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd4;
        return enc_b({r[12:1], 1'b0}, pick(), pick(), f3);
      end
      11: return enc_j({r[20:1], 1'b0}, pick());
      12: return enc_i(imm, pick(), 3'd0, pick(), 7'h67);
      default: begin
        if (r[1:0] == 2'd0) return 32'h0000_000F;
        if (r[1:0] == 2'd1) return 32'h0000_0073;
        if (r[1:0] == 2'd2) return 32'h0010_0073;
        return {r[31:7], 7'h0B};
      end
    endcase
  endfunction

  initial begin
    rst = 1'b0;
    inst = NOP;
    model_reset();
    #12;
    compare_all("reset");
    rst = 1'b1;
    chk_en = 1'b1;

    step(NOP);
    check("nop_pc", inst_addr_o, 32'h0000_0004);
    step(enc_i(12'd0, 5'd0, 3'd0, 5'd26, 7'h13));
    step(enc_i(12'd0, 5'd0, 3'd0, 5'd27, 7'h13));
    step(enc_i(12'd1, 5'd26, 3'd0, 5'd31, 7'h13));
    step(enc_r(7'h00, 5'd27, 5'd26, 3'd3, 5'd30));
    check("li_x31", dut.u_CoNM.u_csregfile.regs[31], 32'd1);
    check("sltu_x30", dut.u_CoNM.u_csregfile.regs[30], 32'd0);
    step(enc_s(12'd1, 5'd31, 5'd27, 3'd0));
    check("sb_byte1", {24'h0, dut.r_mem[1]}, 32'h1);
    check("sb_byte2", {24'h0, dut.r_mem[2]}, 32'h0);
    step(enc_i(12'd1, 5'd27, 3'd1, 5'd29, 7'h03));
    check("lh_x29", dut.u_CoNM.u_csregfile.regs[29], 32'h0000_0001);
    step(enc_j(21'h100, 5'd31));
    check("jal_link", dut.u_CoNM.u_csregfile.regs[31], 32'h0000_0020);
    check("jal_pc", inst_addr_o, 32'h0000_011C);
    for (int i = 0; i < 5; i++) step(enc_i(12'd1, 5'd30, 3'd0, 5'd30, 7'h13));
    check("addi5_x30", dut.u_CoNM.u_csregfile.regs[30], 32'd5);
    check("addi5_pc", inst_addr_o, 32'h0000_0130);
    step(enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13));
    step(enc_i(12'd1, 5'd0, 3'd0, 5'd2, 7'h13));
    step(enc_b(13'd8, 5'd2, 5'd1, 3'd4));
    check("blt_taken_pc", inst_addr_o, 32'h0000_0140);
    step(enc_b(13'd8, 5'd2, 5'd1, 3'd6));
    check("bltu_not_taken_pc", inst_addr_o, 32'h0000_0144);
    step(enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'h13));
    check("x0_stays_zero", dut.u_CoNM.u_csregfile.regs[0], 32'h0);

    for (int n = 0; n < 600; n++) step(gen());

    chk_en = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_pc", inst_addr_o, 32'h0);
    for (int i = 0; i < 32; i++)
      check($sformatf("midrst_x%0d", i), dut.u_CoNM.u_csregfile.regs[i], 32'h0);
    for (int i = 0; i < 256; i++)
      check($sformatf("midrst_mem%0d", i), {24'h0, dut.r_mem[i]}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;
    step(NOP);
    check("restart_pc", inst_addr_o, 32'h0000_0004);

    for (int n = 0; n < 200; n++) step(gen());

    chk_en = 1'b0;
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
